pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Fetch stage directly downstream of the branch/jump resolution logic.
- Consumes the 2-bit branch/jump result and the EX-stage targets, and owns the program counter.
- Issues word requests to instruction memory over a req/ack handshake and delivers fetched instructions to decode over a valid/ready handshake.
- Squashes wrong-path fetches on every redirect.

Parameters:
XLEN, 32, width of PC, targets and instruction word.
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst  input  1  synchronous active-high reset
i_B_J_result  input  2  redirect code: 00 sequential, 01 PC-relative (taken branch/JAL), 11 register-relative (JALR), 10 reserved (treated as 00)
i_Branch_target  input  XLEN  PC+imm computed in EX
i_Jalr_target  input  XLEN  rs1+imm computed in EX
i_Stall  input  1  hazard stall; freezes PC advance and new requests
o_Imem_req  output  1  instruction memory request
o_Imem_addr  output  XLEN  request address, word aligned
i_Imem_ack  input  1  request accepted and i_Imem_rdata valid this cycle
i_Imem_rdata  input  XLEN  fetched instruction
o_Instr  output  XLEN  instruction to decode
o_Instr_pc  output  XLEN  PC of o_Instr
o_Instr_valid  output  1  o_Instr/o_Instr_pc valid
i_Id_ready  input  1  decode accepts this cycle
o_Flush  output  1  one-cycle pulse: squash IF/ID and ID/EX contents

Behaviour:
- Reset values:
  - PC = RESET_VECTOR; state = S_REQ.
  - o_Imem_req = 0; o_Imem_addr = RESET_VECTOR.
  - o_Instr = 0; o_Instr_pc = 0; o_Instr_valid = 0; o_Flush = 0.
  - o_Imem_req first rises the cycle after i_rst deasserts.
- Redirect target:
  - 01 → i_Branch_target.
  - 11 → {i_Jalr_target[XLEN-1:1], 1'b0}.
  - PC = target & ~3 (bits [1:0] forced to 0).
- Redirect priority: a redirect overrides i_Stall, i_Id_ready and i_Imem_ack in the same cycle. On the next edge:
  - PC <= target;
  - o_Instr_valid <= 0;
  - o_Flush <= 1 for exactly one cycle.
- Sequential advance: PC <= PC+4 (mod 2^XLEN, wrap from 32'hFFFF_FFFC to 0) when an ack is consumed into the output register.
- FSM states:
  - S_REQ: o_Imem_req = !i_Stall && !(o_Instr_valid && !i_Id_ready); o_Imem_addr = PC.
    - ack with no redirect: o_Instr <= rdata; o_Instr_pc <= PC; o_Instr_valid <= 1; PC += 4; stay in S_REQ.
    - ack with redirect: data dropped, PC <= target, stay in S_REQ.
  - Request hold rule: once o_Imem_req=1 without ack, req and addr are held stable until ack, even if i_Stall rises.
  - S_DRAIN: entered when a redirect occurs while a request is outstanding (req=1, no ack).
    - req stays high at the old address until ack; the response is discarded.
    - Then → S_REQ with the new PC.
    - A further redirect during S_DRAIN updates PC only; o_Flush pulses again.
- Output handshake:
  - o_Instr_valid && !i_Id_ready → output register holds.
  - Accepted with no new ack → o_Instr_valid <= 0.
  - Accept and ack in the same cycle → register reloads back-to-back.
- Throughput: with combinational ack and ready, one instruction per cycle.
- Redirect latency:
  - Redirect sampled at edge N → o_Imem_addr = target from cycle N+1 (no drain).
  - o_Instr_valid for target earliest at N+2.
- Reset mid-transaction: immediate return to reset values; an in-flight ack after reset is ignored (req=0).

Optional Feature:
- Macro FETCH_MISALIGN_TRAP_EN.
- When defined:
  - Adds output o_Misaligned (1 bit, reset 0).
  - A redirect target with bits [1:0] != 0 sets o_Misaligned=1 and loads o_Instr_pc = the raw target.
  - Fetching halts (o_Imem_req=0) until i_rst.
- When undefined: the port is absent and the target is silently aligned as above.

Decomposition:
- Shared package: redirect-code constants (BJ_SEQ=2'b00, BJ_PCREL=2'b01, BJ_JALR=2'b11), FSM state enum {S_REQ, S_DRAIN}, RESET_VECTOR default, NOP encoding 32'h0000_0013.
- Sub-module: next_pc_sel (combinational target mux + alignment); everything else stays in one module.

Test Plan:
- Reset release, ack always 1, ready always 1 → addresses 0,4,8,12 on consecutive cycles; o_Instr_pc tracks them with 1-cycle lag.
- i_B_J_result=01, i_Branch_target=32'h100 at cycle N → o_Flush=1 at N+1; o_Imem_addr=32'h100 at N+1; the instruction at 0x100 is valid at N+2.
- i_B_J_result=11, i_Jalr_target=32'h203 → fetch address 32'h200; with FETCH_MISALIGN_TRAP_EN: o_Misaligned=1, o_Instr_pc=32'h203, req=0 thereafter.
- Ack delayed 3 cycles, redirect to 0x40 in the second wait cycle → old address held until ack; its data never appears valid; next request at 0x40.
- i_Id_ready=0 for 4 cycles with valid high → o_Instr and o_Instr_pc stable, no new request; after ready=1 the stream resumes with no gap or duplicate.
- Start at PC=32'hFFFF_FFFC via redirect → next sequential address 0; i_rst asserted mid-wait → next cycle req=0, valid=0; after release, fetch resumes at RESET_VECTOR.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: redirect codes, FSM states, reset vector, NOP.
package pc_fetch_unit_pkg;

  localparam logic [1:0]  BJ_SEQ   = 2'b00;
  localparam logic [1:0]  BJ_PCREL = 2'b01;
  localparam logic [1:0]  BJ_JALR  = 2'b11;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;

  typedef enum logic {
    S_REQ,
    S_DRAIN
  } state_e;

endpackage

// File: rtl/pc_fetch_unit_next_pc_sel.sv
// Redirect decode and target mux; targets are forced to word alignment.
// FETCH_MISALIGN_TRAP_EN adds the raw target and a misalignment flag.
module next_pc_sel
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [1:0]      bj_result_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic [XLEN-1:0] jalr_target_i,
  output logic            redirect_o,
  output logic [XLEN-1:0] target_o
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic [XLEN-1:0] target_raw_o,
  output logic            misaligned_o
`endif
);

  logic [XLEN-1:0] sel;

  always_comb begin
    redirect_o = 1'b0;
    sel        = branch_target_i;
    case (bj_result_i)
      BJ_PCREL: begin
        redirect_o = 1'b1;
        sel        = branch_target_i;
      end
      BJ_JALR: begin
        redirect_o = 1'b1;
        sel        = jalr_target_i & ~XLEN'(1);
      end
      default: ;
    endcase
  end

  assign target_o = sel & ~XLEN'(3);

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target_raw_o = (bj_result_i == BJ_JALR) ? jalr_target_i : branch_target_i;
  assign misaligned_o = redirect_o && (sel[1:0] != 2'b00);
`endif

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, issues imem req/ack requests, feeds decode via valid/ready.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect sets o_Misaligned and halts fetch.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [1:0]      i_B_J_result,
  input  logic [XLEN-1:0] i_Branch_target,
  input  logic [XLEN-1:0] i_Jalr_target,
  input  logic            i_Stall,
  output logic            o_Imem_req,
  output logic [XLEN-1:0] o_Imem_addr,
  input  logic            i_Imem_ack,
  input  logic [XLEN-1:0] i_Imem_rdata,
  output logic [XLEN-1:0] o_Instr,
  output logic [XLEN-1:0] o_Instr_pc,
  output logic            o_Instr_valid,
  input  logic            i_Id_ready,
  output logic            o_Flush
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            o_Misaligned
`endif
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] drain_addr_q, drain_addr_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            valid_q, valid_d;
  logic            flush_q, flush_d;
  logic            pend_q, pend_d;
  logic            run_q;
  logic            halt;
  logic            ack;
  logic            redirect;
  logic [XLEN-1:0] target;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic            mis_q, mis_d;
  logic [XLEN-1:0] target_raw;
  logic            misaligned;
`endif

  next_pc_sel #(.XLEN(XLEN)) u_next_pc_sel (
    .bj_result_i     (i_B_J_result),
    .branch_target_i (i_Branch_target),
    .jalr_target_i   (i_Jalr_target),
    .redirect_o      (redirect),
    .target_o        (target)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .target_raw_o    (target_raw),
    .misaligned_o    (misaligned)
`endif
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    valid_d      = valid_q;
    flush_d      = 1'b0;
    o_Imem_req   = 1'b0;
    o_Imem_addr  = pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    mis_d        = mis_q;
    halt         = mis_q;
`else
    halt         = 1'b0;
`endif

    // pend_q keeps an unacked request alive regardless of stall/backpressure
    if (state_q == S_DRAIN) begin
      o_Imem_req  = run_q && !halt;
      o_Imem_addr = drain_addr_q;
    end else begin
      o_Imem_req  = run_q && !halt &&
                    (pend_q || (!i_Stall && !(valid_q && !i_Id_ready)));
      o_Imem_addr = pc_q;
    end

    ack    = o_Imem_req && i_Imem_ack;
    pend_d = o_Imem_req && !ack;

    if (valid_q && i_Id_ready) valid_d = 1'b0;

    if (redirect && !halt) begin
      pc_d    = target;
      valid_d = 1'b0;
      flush_d = 1'b1;
      if (state_q == S_DRAIN) begin
        if (ack) state_d = S_REQ;
      end else if (o_Imem_req && !ack) begin
        state_d      = S_DRAIN;
        drain_addr_d = pc_q;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      if (misaligned) begin
        mis_d      = 1'b1;
        instr_pc_d = target_raw;
      end
`endif
    end else if (ack) begin
      if (state_q == S_DRAIN) begin
        state_d = S_REQ;
      end else begin
        instr_d    = i_Imem_rdata;
        instr_pc_d = pc_q;
        valid_d    = 1'b1;
        pc_d       = pc_q + XLEN'(4);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_VECTOR;
      drain_addr_q <= RESET_VECTOR;
      instr_q      <= '0;
      instr_pc_q   <= '0;
      valid_q      <= 1'b0;
      flush_q      <= 1'b0;
      pend_q       <= 1'b0;
      run_q        <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      valid_q      <= valid_d;
      flush_q      <= flush_d;
      pend_q       <= pend_d;
      run_q        <= 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q        <= mis_d;
`endif
    end
  end

  assign o_Instr       = instr_q;
  assign o_Instr_pc    = instr_pc_q;
  assign o_Instr_valid = valid_q;
  assign o_Flush       = flush_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign o_Misaligned  = mis_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit; imem returns rdata = addr + 32'h1000_0000 combinationally.
module tb_pc_fetch_unit;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [1:0]  i_B_J_result;
  logic [31:0] i_Branch_target;
  logic [31:0] i_Jalr_target;
  logic        i_Stall;
  logic        o_Imem_req;
  logic [31:0] o_Imem_addr;
  logic        i_Imem_ack;
  logic [31:0] i_Imem_rdata;
  logic [31:0] o_Instr;
  logic [31:0] o_Instr_pc;
  logic        o_Instr_valid;
  logic        i_Id_ready;
  logic        o_Flush;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        o_Misaligned;
`endif

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  always #5 i_clk = ~i_clk;

  assign i_Imem_rdata = o_Imem_addr + 32'h1000_0000;

  pc_fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_0000)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_B_J_result    (i_B_J_result),
    .i_Branch_target (i_Branch_target),
    .i_Jalr_target   (i_Jalr_target),
    .i_Stall         (i_Stall),
    .o_Imem_req      (o_Imem_req),
    .o_Imem_addr     (o_Imem_addr),
    .i_Imem_ack      (i_Imem_ack),
    .i_Imem_rdata    (i_Imem_rdata),
    .o_Instr         (o_Instr),
    .o_Instr_pc      (o_Instr_pc),
    .o_Instr_valid   (o_Instr_valid),
    .i_Id_ready      (i_Id_ready),
    .o_Flush         (o_Flush)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .o_Misaligned    (o_Misaligned)
`endif
  );

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_B_J_result = 2'b00; i_Branch_target = '0; i_Jalr_target = '0;
    i_Stall = 1'b0; i_Imem_ack = 1'b0; i_Id_ready = 1'b1;
    cyc(); cyc();
    i_rst = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_B_J_result = 2'b00; i_Branch_target = '0; i_Jalr_target = '0;
    i_Stall = 1'b0; i_Imem_ack = 1'b1; i_Id_ready = 1'b1;
    cyc(); cyc();
    total_cnt++; if (o_Imem_req !== 1'b0) $display("FAIL rst_req: got %b expected 0", o_Imem_req); else pass_cnt++;
    total_cnt++; if (o_Imem_addr !== 32'h0) $display("FAIL rst_addr: got %h expected 0", o_Imem_addr); else pass_cnt++;
    total_cnt++; if (o_Instr !== 32'h0) $display("FAIL rst_instr: got %h expected 0", o_Instr); else pass_cnt++;
    total_cnt++; if (o_Instr_pc !== 32'h0) $display("FAIL rst_instr_pc: got %h expected 0", o_Instr_pc); else pass_cnt++;
    total_cnt++; if (o_Instr_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", o_Instr_valid); else pass_cnt++;
    total_cnt++; if (o_Flush !== 1'b0) $display("FAIL rst_flush: got %b expected 0", o_Flush); else pass_cnt++;
    i_rst = 1'b0;
    #1;
    total_cnt++; if (o_Imem_req !== 1'b0) $display("FAIL rst_release_req: got %b expected 0", o_Imem_req); else pass_cnt++;
    cyc();
    total_cnt++; if (o_Imem_req !== 1'b1) $display("FAIL rst_first_req: got %b expected 1", o_Imem_req); else pass_cnt++;
  endtask

  task automatic test_sequential();
    do_reset();
    i_Imem_ack = 1'b1; i_Id_ready = 1'b1;
    #1;
    total_cnt++; if (o_Imem_addr !== 32'h0) $display("FAIL seq_addr0: got %h expected 0", o_Imem_addr); else pass_cnt++;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      total_cnt++; if (o_Imem_addr !== 32'(4 * i)) $display("FAIL seq_addr: got %h expected %h", o_Imem_addr, 32'(4 * i)); else pass_cnt++;
      total_cnt++; if (o_Instr_pc !== 32'(4 * (i - 1))) $display("FAIL seq_pc: got %h expected %h", o_Instr_pc, 32'(4 * (i - 1))); else pass_cnt++;
      total_cnt++; if (o_Instr !== 32'h1000_0000 + 32'(4 * (i - 1))) $display("FAIL seq_instr: got %h expected %h", o_Instr, 32'h1000_0000 + 32'(4 * (i - 1))); else pass_cnt++;
      total_cnt++; if (o_Instr_valid !== 1'b1) $display("FAIL seq_valid: got %b expected 1", o_Instr_valid); else pass_cnt++;
    end
  endtask

  task automatic test_branch();
    do_reset();
    i_Imem_ack = 1'b1;
    #1;
    cyc();
    i_B_J_result = 2'b01; i_Branch_target = 32'h100;
    cyc();
    i_B_J_result = 2'b00;
    #1;
    total_cnt++; if (o_Flush !== 1'b1) $display("FAIL br_flush: got %b expected 1", o_Flush); else pass_cnt++;
    total_cnt++; if (o_Imem_addr !== 32'h100) $display("FAIL br_addr: got %h expected 100", o_Imem_addr); else pass_cnt++;
    total_cnt++; if (o_Instr_valid !== 1'b0) $display("FAIL br_squash: got %b expected 0", o_Instr_valid); else pass_cnt++;
    cyc();
    total_cnt++; if (o_Flush !== 1'b0) $display("FAIL br_flush_end: got %b expected 0", o_Flush); else pass_cnt++;
    total_cnt++; if (o_Instr_valid !== 1'b1) $display("FAIL br_valid: got %b expected 1", o_Instr_valid); else pass_cnt++;
    total_cnt++; if (o_Instr_pc !== 32'h100) $display("FAIL br_pc: got %h expected 100", o_Instr_pc); else pass_cnt++;
    total_cnt++; if (o_Instr !== 32'h1000_0100) $display("FAIL br_instr: got %h expected 10000100", o_Instr); else pass_cnt++;
    total_cnt++; if (o_Imem_addr !== 32'h104) $display("FAIL br_next: got %h expected 104", o_Imem_addr); else pass_cnt++;
  endtask

  task automatic test_jalr();
    do_reset();
    i_Imem_ack = 1'b1;
    i_B_J_result = 2'b11; i_Jalr_target = 32'h203;
    #1;
    cyc();
    i_B_J_result = 2'b00;
    #1;
    total_cnt++; if (o_Flush !== 1'b1) $display("FAIL jalr_flush: got %b expected 1", o_Flush); else pass_cnt++;
`ifdef FETCH_MISALIGN_TRAP_EN
    total_cnt++; if (o_Misaligned !== 1'b1) $display("FAIL jalr_mis: got %b expected 1", o_Misaligned); else pass_cnt++;
    total_cnt++; if (o_Instr_pc !== 32'h203) $display("FAIL jalr_raw_pc: got %h expected 203", o_Instr_pc); else pass_cnt++;
    total_cnt++; if (o_Imem_req !== 1'b0) $display("FAIL jalr_halt_req: got %b expected 0", o_Imem_req); else pass_cnt++;
    cyc(); cyc();
    total_cnt++; if (o_Imem_req !== 1'b0) $display("FAIL jalr_halt_hold: got %b expected 0", o_Imem_req); else pass_cnt++;
    total_cnt++; if (o_Instr_valid !== 1'b0) $display("FAIL jalr_halt_valid: got %b expected 0", o_Instr_valid); else pass_cnt++;
`else
    total_cnt++; if (o_Imem_addr !== 32'h200) $display("FAIL jalr_addr: got %h expected 200", o_Imem_addr); else pass_cnt++;
    cyc();
    total_cnt++; if (o_Instr_pc !== 32'h200) $display("FAIL jalr_pc: got %h expected 200", o_Instr_pc); else pass_cnt++;
    total_cnt++; if (o_Instr_valid !== 1'b1) $display("FAIL jalr_valid: got %b expected 1", o_Instr_valid); else pass_cnt++;
`endif
  endtask

  task automatic test_drain();
    do_reset();
    i_Imem_ack = 1'b0;
    #1;
    total_cnt++; if (o_Imem_req !== 1'b1 || o_Imem_addr !== 32'h0) $display("FAIL drain_req0: got req=%b addr=%h expected 1/0", o_Imem_req, o_Imem_addr); else pass_cnt++;
    cyc();
    i_B_J_result = 2'b01; i_Branch_target = 32'h40;
    #1;
    total_cnt++; if (o_Imem_addr !== 32'h0) $display("FAIL drain_hold1: got %h expected 0", o_Imem_addr); else pass_cnt++;
    cyc();
    i_B_J_result = 2'b00;
    #1;
    total_cnt++; if (o_Flush !== 1'b1) $display("FAIL drain_flush: got %b expected 1", o_Flush); else pass_cnt++;
    total_cnt++; if (o_Imem_req !== 1'b1 || o_Imem_addr !== 32'h0) $display("FAIL drain_hold2: got req=%b addr=%h expected 1/0", o_Imem_req, o_Imem_addr); else pass_cnt++;
    i_Imem_ack = 1'b1;
    cyc();
    total_cnt++; if (o_Instr_valid !== 1'b0) $display("FAIL drain_discard: got %b expected 0", o_Instr_valid); else pass_cnt++;
    total_cnt++; if (o_Imem_addr !== 32'h40) $display("FAIL drain_new_addr: got %h expected 40", o_Imem_addr); else pass_cnt++;
    cyc();
    total_cnt++; if (o_Instr_valid !== 1'b1 || o_Instr_pc !== 32'h40) $display("FAIL drain_resume: got v=%b pc=%h expected 1/40", o_Instr_valid, o_Instr_pc); else pass_cnt++;
    total_cnt++; if (o_Instr !== 32'h1000_0040) $display("FAIL drain_instr: got %h expected 10000040", o_Instr); else pass_cnt++;
  endtask

  task automatic test_stall();
    do_reset();
    i_Stall = 1'b1; i_Imem_ack = 1'b1;
    #1;
    total_cnt++; if (o_Imem_req !== 1'b0) $display("FAIL stall_req: got %b expected 0", o_Imem_req); else pass_cnt++;
    cyc();
    total_cnt++; if (o_Instr_valid !== 1'b0) $display("FAIL stall_valid: got %b expected 0", o_Instr_valid); else pass_cnt++;
    i_Stall = 1'b0; i_Imem_ack = 1'b0;
    cyc();
    i_Stall = 1'b1;
    #1;
    total_cnt++; if (o_Imem_req !== 1'b1 || o_Imem_addr !== 32'h0) $display("FAIL stall_hold: got req=%b addr=%h expected 1/0", o_Imem_req, o_Imem_addr); else pass_cnt++;
    i_Imem_ack = 1'b1;
    cyc();
    total_cnt++; if (o_Instr_valid !== 1'b1 || o_Instr_pc !== 32'h0) $display("FAIL stall_ack: got v=%b pc=%h expected 1/0", o_Instr_valid, o_Instr_pc); else pass_cnt++;
    total_cnt++; if (o_Imem_req !== 1'b0) $display("FAIL stall_after: got %b expected 0", o_Imem_req); else pass_cnt++;
    i_Stall = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    i_Imem_ack = 1'b1;
    cyc(); cyc();
    i_Id_ready = 1'b0;
    #1;
    total_cnt++; if (o_Imem_req !== 1'b0) $display("FAIL bp_req: got %b expected 0", o_Imem_req); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      cyc();
      total_cnt++; if (o_Instr_valid !== 1'b1 || o_Instr_pc !== 32'h4 || o_Instr !== 32'h1000_0004) $display("FAIL bp_hold: got v=%b pc=%h instr=%h expected 1/4/10000004", o_Instr_valid, o_Instr_pc, o_Instr); else pass_cnt++;
      total_cnt++; if (o_Imem_req !== 1'b0) $display("FAIL bp_noreq: got %b expected 0", o_Imem_req); else pass_cnt++;
    end
    i_Id_ready = 1'b1;
    #1;
    total_cnt++; if (o_Imem_req !== 1'b1 || o_Imem_addr !== 32'h8) $display("FAIL bp_resume_req: got req=%b addr=%h expected 1/8", o_Imem_req, o_Imem_addr); else pass_cnt++;
    cyc();
    total_cnt++; if (o_Instr_pc !== 32'h8) $display("FAIL bp_resume_pc8: got %h expected 8", o_Instr_pc); else pass_cnt++;
    cyc();
    total_cnt++; if (o_Instr_pc !== 32'hC) $display("FAIL bp_resume_pcC: got %h expected c", o_Instr_pc); else pass_cnt++;
  endtask

  task automatic test_wrap_reset();
    do_reset();
    i_Imem_ack = 1'b1;
    i_B_J_result = 2'b01; i_Branch_target = 32'hFFFF_FFFC;
    cyc();
    i_B_J_result = 2'b00;
    #1;
    total_cnt++; if (o_Imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr: got %h expected fffffffc", o_Imem_addr); else pass_cnt++;
    cyc();
    total_cnt++; if (o_Imem_addr !== 32'h0) $display("FAIL wrap_next: got %h expected 0", o_Imem_addr); else pass_cnt++;
    total_cnt++; if (o_Instr_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_pc: got %h expected fffffffc", o_Instr_pc); else pass_cnt++;
    cyc();
    i_Imem_ack = 1'b0;
    cyc();
    total_cnt++; if (o_Imem_req !== 1'b1 || o_Imem_addr !== 32'h4) $display("FAIL wrap_wait: got req=%b addr=%h expected 1/4", o_Imem_req, o_Imem_addr); else pass_cnt++;
    i_rst = 1'b1;
    cyc();
    i_Imem_ack = 1'b1;
    #1;
    total_cnt++; if (o_Imem_req !== 1'b0 || o_Instr_valid !== 1'b0) $display("FAIL midrst_state: got req=%b v=%b expected 0/0", o_Imem_req, o_Instr_valid); else pass_cnt++;
    total_cnt++; if (o_Imem_addr !== 32'h0) $display("FAIL midrst_addr: got %h expected 0", o_Imem_addr); else pass_cnt++;
    i_rst = 1'b0;
    cyc();
    total_cnt++; if (o_Instr_valid !== 1'b0) $display("FAIL midrst_ignored_ack: got %b expected 0", o_Instr_valid); else pass_cnt++;
    total_cnt++; if (o_Imem_req !== 1'b1 || o_Imem_addr !== 32'h0) $display("FAIL midrst_resume: got req=%b addr=%h expected 1/0", o_Imem_req, o_Imem_addr); else pass_cnt++;
    cyc();
    total_cnt++; if (o_Instr_valid !== 1'b1 || o_Instr_pc !== 32'h0) $display("FAIL midrst_first: got v=%b pc=%h expected 1/0", o_Instr_valid, o_Instr_pc); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jalr();
    test_drain();
    test_stall();
    test_backpressure();
    test_wrap_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
